// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer with in-order drain; load forwarding when DMEM_STB_FORWARD_EN is defined
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic          cpu_flush,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_valid,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [31:0]   mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t          state_q;
  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            hit, ld, push, pop;
`ifdef DMEM_STB_FORWARD_EN
  logic [31:0]     fwd_data;
`endif
  always_comb begin
    hit = 1'b0;
`ifdef DMEM_STB_FORWARD_EN
    fwd_data = mem_rdata;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[rd_ptr_q + PW'(i)] == cpu_addr[31:2]) begin
        hit = 1'b1;
`ifdef DMEM_STB_FORWARD_EN
        fwd_data = data_q[rd_ptr_q + PW'(i)];
`endif
      end
    end
  end
  assign ld = cpu_re & ~cpu_we;
`ifdef DMEM_STB_FORWARD_EN
  assign cpu_stall = (state_q == FLUSH) | (cpu_we & (count_q == CW'(DEPTH)));
  assign cpu_rdata = (ld & hit) ? fwd_data : mem_rdata;
`else
  assign cpu_stall = (state_q == FLUSH) | (cpu_we & (count_q == CW'(DEPTH))) | (ld & hit);
  assign cpu_rdata = mem_rdata;
`endif
  assign empty     = count_q == '0;
  assign count     = count_q;
  assign mem_valid = ~empty & ~reset;
  assign mem_addr  = {addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = data_q[rd_ptr_q];
  assign mem_raddr = cpu_addr;
  assign push      = cpu_we & ~cpu_stall;
  assign pop       = mem_valid & mem_ready;
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= cpu_addr[31:2];
      data_q[wr_ptr_q] <= cpu_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + CW'(push) - CW'(pop);
      state_q  <= (state_q == RUN) ? (cpu_flush ? FLUSH : RUN) : (empty ? RUN : FLUSH);
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: scoreboard bench for dmem_store_buffer (ordering, stall, forwarding, flush, reset)
module tb_dmem_store_buffer;
  logic        clk = 1'b0;
  logic        reset, cpu_we, cpu_re, cpu_flush, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_raddr, mem_rdata;
  logic        cpu_stall, mem_valid, empty;
  logic [2:0]  count;
  logic [31:0] mem [64];
  logic [63:0] sb [$];
  int          checks = 0, failures = 0;
  dmem_store_buffer dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_flush(cpu_flush),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_raddr[7:2]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max && !empty; i++) tick();
    @(negedge clk);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    tick();
  endtask
  always @(posedge clk) begin
    if (!reset && mem_valid && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
  end
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (cpu_we && !cpu_stall) sb.push_back({cpu_addr & 32'hFFFF_FFFC, cpu_wdata});
      if (mem_valid && mem_ready) begin
        chk("mem_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("mem_addr", mem_addr, e[63:32]);
          chk("mem_wdata", mem_wdata, e[31:0]);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_flush = 1'b0; mem_ready = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    cpu_re = 1'b1; cpu_addr = 32'h64;
    @(negedge clk);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'hA000_0019);
    tick();
    cpu_re = 1'b0; mem_ready = 1'b1;
    cpu_we = 1'b1; cpu_addr = 32'h64; cpu_wdata = 32'h19;
    @(negedge clk);
    chk("t1_valid0", {31'd0, mem_valid}, 32'd0);
    tick();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("t1_valid1", {31'd0, mem_valid}, 32'd1);
    chk("t1_addr", mem_addr, 32'h64);
    chk("t1_data", mem_wdata, 32'h19);
    tick();
    @(negedge clk);
    chk("t1_empty", {31'd0, empty}, 32'd1);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'h100 + 4 * k; cpu_wdata = 32'h200 + k;
      @(negedge clk);
      chk("t2_count", {29'd0, count}, (k < 4) ? k : 4);
      chk("t2_stall", {31'd0, cpu_stall}, (k < 4) ? 0 : 1);
      if (k < 4) tick();
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t2_stall_pop", {31'd0, cpu_stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_count_pop", {29'd0, count}, 32'd3);
    chk("t2_stall_free", {31'd0, cpu_stall}, 32'd0);
    tick();
    cpu_we = 1'b0;
    drain(20);
    mem_ready = 1'b0;
    store(32'h60, 32'hA);
    store(32'h60, 32'hB);
    cpu_re = 1'b1; cpu_addr = 32'h62;
    @(negedge clk);
`ifdef DMEM_STB_FORWARD_EN
    chk("t3_fwd", cpu_rdata, 32'hB);
    chk("t3_nostall", {31'd0, cpu_stall}, 32'd0);
`else
    chk("t3_stall", {31'd0, cpu_stall}, 32'd1);
    chk("t3_rdata", cpu_rdata, 32'hA000_0018);
`endif
    tick();
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
`ifdef DMEM_STB_FORWARD_EN
    chk("t3_fwd_b", cpu_rdata, 32'hB);
`else
    chk("t3_stall_b", {31'd0, cpu_stall}, 32'd1);
`endif
    tick();
    @(negedge clk);
    chk("t3_stall_end", {31'd0, cpu_stall}, 32'd0);
    chk("t3_rdata_end", cpu_rdata, 32'hB);
    tick();
    cpu_re = 1'b0;
    mem_ready = 1'b0;
    store(32'h300, 32'h300);
    store(32'h304, 32'h301);
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'h308 + 4 * k; cpu_wdata = 32'h302 + k;
      @(negedge clk);
      chk("t4_count", {29'd0, count}, 32'd2);
      chk("t4_stall", {31'd0, cpu_stall}, 32'd0);
      tick();
    end
    cpu_we = 1'b0;
    drain(20);
    chk("t4_sb", sb.size(), 32'd0);
    mem_ready = 1'b0;
    store(32'h400, 32'h40);
    store(32'h404, 32'h41);
    store(32'h408, 32'h42);
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    @(negedge clk);
    chk("t5_stall_a", {31'd0, cpu_stall}, 32'd1);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_count3", {29'd0, count}, 32'd3);
    chk("t5_stall_b", {31'd0, cpu_stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_count2", {29'd0, count}, 32'd2);
    tick();
    tick();
    @(negedge clk);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    chk("t5_stall_c", {31'd0, cpu_stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_stall_off", {31'd0, cpu_stall}, 32'd0);
    tick();
    mem_ready = 1'b0;
    store(32'h500, 32'h50);
    store(32'h504, 32'h51);
    store(32'h508, 32'h52);
    @(negedge clk);
    chk("t6_count3", {29'd0, count}, 32'd3);
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid_rst", {31'd0, mem_valid}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_valid", {31'd0, mem_valid}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    repeat (4) tick();
    chk("end_sb", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the single-cycle core's data-memory port (MemWrite / DataAdr / WriteData / ReadData) and a data memory that accepts writes through a valid/ready handshake. Stores complete in the core's cycle and are queued, then drained in program order. Loads see the youngest queued value for their word address. The core is stalled only when the buffer is full, on a flush, or on a load hazard when forwarding is compiled out.

## Interface
Parameters:
- DEPTH, 4, number of queued stores; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived)

Ports:
- clk  input  1  core clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- cpu_we  input  1  store request (core MemWrite)
- cpu_re  input  1  load request
- cpu_flush  input  1  request full drain; level, sampled each cycle
- cpu_addr  input  32  byte address; bits [1:0] ignored (word access only)
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data to core (combinational)
- cpu_stall  output  1  core must hold PC and not commit the current instruction
- mem_valid  output  1  head entry offered to memory
- mem_addr  output  32  head entry word address, {addr[31:2], 2'b00}
- mem_wdata  output  32  head entry data
- mem_ready  input  1  memory accepts the head entry this cycle
- mem_raddr  output  32  load address to memory; equals cpu_addr (combinational)
- mem_rdata  input  32  memory read data for mem_raddr (combinational)
- count  output  CW  current occupancy
- empty  output  1  count == 0

## Operation
- Circular FIFO: DEPTH entries {addr[31:2], data}, rd_ptr, wr_ptr, count; pointers wrap modulo DEPTH.
- Push: cpu_we & ~cpu_stall writes the entry at wr_ptr; wr_ptr++, count++.
- Full (count == DEPTH): cpu_stall = 1 while cpu_we, even if a pop occurs in the same cycle. The store is accepted the next cycle.
- Pop: mem_valid & mem_ready; rd_ptr++, count--. mem_valid = ~empty. mem_addr and mem_wdata are the head entry and hold stable while mem_valid & ~mem_ready.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Load: compare cpu_addr[31:2] against all occupied entries.
  - If any entry matches, cpu_rdata = data of the youngest match.
  - If none match, cpu_rdata = mem_rdata.
- cpu_we & cpu_re together is illegal. The block treats it as a store, and cpu_rdata = mem_rdata.
- FSM:
  - RUN: normal operation. cpu_flush moves to FLUSH.
  - FLUSH: cpu_stall = 1; no pushes; drains continue. Returns to RUN in the cycle after empty is observed.
  - cpu_flush with empty buffer: one stall cycle, then RUN.
- Memory sees stores strictly in program order. Same-address stores are never merged.

## Timing
- Reset values: count 0, empty 1, mem_valid 0, cpu_stall 0, FSM RUN, pointers 0. Entry storage is not cleared.
- cpu_rdata follows mem_rdata out of reset (combinational).
- Reset asserted mid-operation discards all queued stores. No memory transfer occurs in the reset cycle.
- Store accepted at edge N:
  - forwardable to loads from cycle N+1
  - mem_valid high from cycle N+1 at the earliest
- Min store-to-memory latency: 1 cycle. Sustained throughput is 1 store/cycle with mem_ready held high.
- cpu_stall is combinational from cpu_we, cpu_re, cpu_addr, count and the FSM state. It has no dependence on mem_ready.

## Configuration
- DMEM_STB_FORWARD_EN defined: load forwarding as described; loads never stall.
- Not defined: no forwarding path. A load whose word address matches any occupied entry asserts cpu_stall until no match remains; cpu_rdata is always mem_rdata. Non-matching loads proceed without stall.

## Test plan
- Reset, then store 0x19 to 0x64 with mem_ready=1 → mem_valid high next cycle with mem_addr=0x64, mem_wdata=0x19; empty=1 one cycle later.
- mem_ready=0, 5 stores with DEPTH=4 → count=4, cpu_stall=1 on the 5th. Raise mem_ready → 5th accepted the cycle after a pop; memory receives all 5 in order.
- Store 0xA to 0x60, then 0xB to 0x60, then load 0x62 with mem_ready=0 → cpu_rdata=0xB (FORWARD_EN). Without FORWARD_EN: stall until both entries drain, then cpu_rdata=mem_rdata.
- Buffer at count=2 with mem_ready=1, issue a store each cycle → count stays 2; pointers wrap past DEPTH-1 with no lost or duplicated entries.
- Three stores queued, mem_ready=0, pulse cpu_flush → cpu_stall stays high. Release mem_ready → 3 pops, then cpu_stall drops the cycle after empty=1.
- Reset asserted with count=3 → next cycle count=0, mem_valid=0, empty=1; no further memory writes.
